// File: rtl/depar_rewrite_top.sv
// Deparser: pairs each packet with one PHV and overwrites the leading
// C_HDR_BEATS beats with PHV header slices, with discard and bypass support.
module depar_rewrite_top #(
    parameter int         C_AXIS_DATA_WIDTH  = 256,
    parameter int         C_AXIS_TUSER_WIDTH = 128,
    parameter int         C_HDR_BEATS        = 4,
    parameter int         C_META_WIDTH       = 256,
    parameter int         C_PKT_VEC_WIDTH    = C_HDR_BEATS*C_AXIS_DATA_WIDTH+C_META_WIDTH,
    parameter logic [2:0] DEPARSER_MOD_ID    = 3'b101
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      pkt_fifo_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    pkt_fifo_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     pkt_fifo_tuser,
    input  logic                              pkt_fifo_tlast,
    input  logic                              pkt_fifo_empty,
    output logic                              pkt_fifo_rd_en,
    input  logic [C_PKT_VEC_WIDTH-1:0]        phv_fifo_out,
    input  logic                              phv_fifo_empty,
    output logic                              phv_fifo_rd_en,
    output logic [C_AXIS_DATA_WIDTH-1:0]      depar_out_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    depar_out_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     depar_out_tuser,
    output logic                              depar_out_tvalid,
    output logic                              depar_out_tlast,
    input  logic                              depar_out_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      ctrl_s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     ctrl_s_axis_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    ctrl_s_axis_tkeep,
    input  logic                              ctrl_s_axis_tvalid,
    input  logic                              ctrl_s_axis_tlast
);

    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int KW    = C_AXIS_DATA_WIDTH/8;
    localparam int UW    = C_AXIS_TUSER_WIDTH;
    localparam int HDR_W = C_HDR_BEATS*C_AXIS_DATA_WIDTH;
    localparam int CNT_W = $clog2(C_HDR_BEATS+1);
    localparam logic [CNT_W-1:0] HDR_CNT = CNT_W'(C_HDR_BEATS);

    typedef enum logic [1:0] {IDLE, EMIT, DROP} state_e;

    state_e             state_q, state_d;
    logic [HDR_W-1:0]   hdr_q, hdr_d;
    logic               bypass_q, bypass_d;
    logic               pkt_bypass_q, pkt_bypass_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]      out_tdata_q, out_tdata_d;
    logic [KW-1:0]      out_tkeep_q, out_tkeep_d;
    logic [UW-1:0]      out_tuser_q, out_tuser_d;
    logic               out_tlast_q, out_tlast_d;
    logic               out_tvalid_q, out_tvalid_d;

    logic               pop;
    logic               pkt_rd;
    logic               phv_rd;
    logic [DW-1:0]      slice_sel;
    logic               unused_inputs;

    assign unused_inputs = ^{ctrl_s_axis_tuser, ctrl_s_axis_tkeep, ctrl_s_axis_tlast,
                             ctrl_s_axis_tdata[DW-1:5], phv_fifo_out[C_META_WIDTH-1:1]};

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        bypass_d     = bypass_q;
        pkt_bypass_d = pkt_bypass_q;
        beat_cnt_d   = beat_cnt_q;
        out_tdata_d  = out_tdata_q;
        out_tkeep_d  = out_tkeep_q;
        out_tuser_d  = out_tuser_q;
        out_tlast_d  = out_tlast_q;
        out_tvalid_d = out_tvalid_q;
        pop          = 1'b0;
        pkt_rd       = 1'b0;
        phv_rd       = 1'b0;
        slice_sel    = '0;

        for (int unsigned i = 0; i < C_HDR_BEATS; i++) begin
            if (beat_cnt_q == CNT_W'(i)) begin
                slice_sel = hdr_q[HDR_W-1-i*DW -: DW];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (!pkt_fifo_empty && !phv_fifo_empty) begin
                    phv_rd       = 1'b1;
                    hdr_d        = phv_fifo_out[C_PKT_VEC_WIDTH-1 -: HDR_W];
                    beat_cnt_d   = '0;
                    pkt_bypass_d = bypass_q;
                    state_d      = phv_fifo_out[0] ? DROP : EMIT;
                end
            end
            EMIT: begin
                pop    = !pkt_fifo_empty && (!out_tvalid_q || depar_out_tready);
                pkt_rd = pop;
                if (pop) begin
                    out_tdata_d = (beat_cnt_q < HDR_CNT && !pkt_bypass_q) ? slice_sel
                                                                           : pkt_fifo_tdata;
                    out_tkeep_d = pkt_fifo_tkeep;
                    out_tuser_d = pkt_fifo_tuser;
                    out_tlast_d = pkt_fifo_tlast;
                    if (beat_cnt_q < HDR_CNT) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (pkt_fifo_tlast) begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                pkt_rd = !pkt_fifo_empty;
                if (pkt_rd && pkt_fifo_tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop refills the register; otherwise an accepted beat empties it.
        if (pop) begin
            out_tvalid_d = 1'b1;
        end else if (depar_out_tready) begin
            out_tvalid_d = 1'b0;
        end

        if (ctrl_s_axis_tvalid && ctrl_s_axis_tdata[2:0] == DEPARSER_MOD_ID
            && ctrl_s_axis_tdata[3]) begin
            bypass_d = ctrl_s_axis_tdata[4];
        end
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            bypass_q     <= 1'b0;
            pkt_bypass_q <= 1'b0;
            beat_cnt_q   <= '0;
            out_tdata_q  <= '0;
            out_tkeep_q  <= '0;
            out_tuser_q  <= '0;
            out_tlast_q  <= 1'b0;
            out_tvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            bypass_q     <= bypass_d;
            pkt_bypass_q <= pkt_bypass_d;
            beat_cnt_q   <= beat_cnt_d;
            out_tdata_q  <= out_tdata_d;
            out_tkeep_q  <= out_tkeep_d;
            out_tuser_q  <= out_tuser_d;
            out_tlast_q  <= out_tlast_d;
            out_tvalid_q <= out_tvalid_d;
        end
    end

    // Read enables are forced low while reset is held so nothing pops.
    assign pkt_fifo_rd_en   = pkt_rd && aresetn;
    assign phv_fifo_rd_en   = phv_rd && aresetn;
    assign depar_out_tdata  = out_tdata_q;
    assign depar_out_tkeep  = out_tkeep_q;
    assign depar_out_tuser  = out_tuser_q;
    assign depar_out_tlast  = out_tlast_q;
    assign depar_out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_depar_rewrite_top.sv
// Bench for depar_rewrite_top: FIFO models feed the DUT and a packet-level
// reference predicts every output beat from the PHV and bypass mode.
module tb_depar_rewrite_top;

    localparam int W    = 256;
    localparam int TU   = 128;
    localparam int HB   = 4;
    localparam int META = 256;
    localparam int PW   = HB*W+META;
    localparam int KW   = W/8;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic [TU-1:0] user;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [0:HB-1][W-1:0] s;
        logic [META-1:0]      meta;
    } phv_t;

    logic           axis_clk = 1'b0;
    logic           aresetn;
    logic [W-1:0]   pkt_fifo_tdata;
    logic [KW-1:0]  pkt_fifo_tkeep;
    logic [TU-1:0]  pkt_fifo_tuser;
    logic           pkt_fifo_tlast;
    logic           pkt_fifo_empty;
    logic           pkt_fifo_rd_en;
    logic [PW-1:0]  phv_fifo_out;
    logic           phv_fifo_empty;
    logic           phv_fifo_rd_en;
    logic [W-1:0]   depar_out_tdata;
    logic [KW-1:0]  depar_out_tkeep;
    logic [TU-1:0]  depar_out_tuser;
    logic           depar_out_tvalid;
    logic           depar_out_tlast;
    logic           depar_out_tready;
    logic [W-1:0]   ctrl_s_axis_tdata;
    logic [TU-1:0]  ctrl_s_axis_tuser;
    logic [KW-1:0]  ctrl_s_axis_tkeep;
    logic           ctrl_s_axis_tvalid;
    logic           ctrl_s_axis_tlast;

    depar_rewrite_top #(
        .C_AXIS_DATA_WIDTH (W),
        .C_AXIS_TUSER_WIDTH(TU),
        .C_HDR_BEATS       (HB),
        .C_META_WIDTH      (META),
        .DEPARSER_MOD_ID   (3'b101)
    ) dut (
        .axis_clk          (axis_clk),
        .aresetn           (aresetn),
        .pkt_fifo_tdata    (pkt_fifo_tdata),
        .pkt_fifo_tkeep    (pkt_fifo_tkeep),
        .pkt_fifo_tuser    (pkt_fifo_tuser),
        .pkt_fifo_tlast    (pkt_fifo_tlast),
        .pkt_fifo_empty    (pkt_fifo_empty),
        .pkt_fifo_rd_en    (pkt_fifo_rd_en),
        .phv_fifo_out      (phv_fifo_out),
        .phv_fifo_empty    (phv_fifo_empty),
        .phv_fifo_rd_en    (phv_fifo_rd_en),
        .depar_out_tdata   (depar_out_tdata),
        .depar_out_tkeep   (depar_out_tkeep),
        .depar_out_tuser   (depar_out_tuser),
        .depar_out_tvalid  (depar_out_tvalid),
        .depar_out_tlast   (depar_out_tlast),
        .depar_out_tready  (depar_out_tready),
        .ctrl_s_axis_tdata (ctrl_s_axis_tdata),
        .ctrl_s_axis_tuser (ctrl_s_axis_tuser),
        .ctrl_s_axis_tkeep (ctrl_s_axis_tkeep),
        .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
        .ctrl_s_axis_tlast (ctrl_s_axis_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    beat_t pkt_q[$];
    phv_t  phv_q[$];
    beat_t exp_q[$];
    beat_t got_log[$];

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          ready_mode = 0;
    int          pkt_pops = 0;
    int          phv_pulses = 0;
    int          beats_out = 0;
    logic        busy = 1'b0;
    logic        cur_drop = 1'b0;
    logic        bypass_m = 1'b0;
    logic        stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic        ctrl_go = 1'b0;
    logic [4:0]  ctrl_cmd = '0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_pkt(input int len, input bit idx_data);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = idx_data ? W'(k) : rand_word();
            b.keep = ($urandom_range(0, 3) == 0) ? KW'($urandom) : '1;
            b.user = TU'(rand_word());
            b.last = (k == len-1);
            pkt_q.push_back(b);
        end
    endtask

    task automatic push_phv(input bit discard, input bit fixed);
        phv_t p;
        for (int i = 0; i < HB; i++) p.s[i] = fixed ? W'(8'hA0 + i) : rand_word();
        p.meta    = META'(rand_word());
        p.meta[0] = discard;
        phv_q.push_back(p);
    endtask

    // One clock: drive FIFO heads, check handshakes, then advance the model.
    task automatic cycle();
        logic  do_pkt, do_phv, accept;
        beat_t e;
        phv_t  ph;
        pkt_fifo_empty = (pkt_q.size() == 0);
        if (pkt_q.size() != 0) begin
            pkt_fifo_tdata = pkt_q[0].data;
            pkt_fifo_tkeep = pkt_q[0].keep;
            pkt_fifo_tuser = pkt_q[0].user;
            pkt_fifo_tlast = pkt_q[0].last;
        end else begin
            pkt_fifo_tdata = '0; pkt_fifo_tkeep = '0; pkt_fifo_tuser = '0; pkt_fifo_tlast = 1'b0;
        end
        phv_fifo_empty = (phv_q.size() == 0);
        phv_fifo_out   = (phv_q.size() != 0) ? PW'(phv_q[0]) : '0;
        case (ready_mode)
            0: depar_out_tready = 1'b1;
            1: depar_out_tready = ($urandom_range(0, 3) != 0);
            default: depar_out_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
        endcase
        ctrl_s_axis_tvalid = ctrl_go;
        ctrl_s_axis_tdata  = ctrl_go ? W'(ctrl_cmd) : '0;
        #1;
        if (stall_prev) begin
            chk("stall_valid", W'(depar_out_tvalid), W'(1));
            chk("stall_data", depar_out_tdata, prev_data);
        end
        if (busy && !cur_drop && depar_out_tvalid && !depar_out_tready)
            chk("stall_no_pop", W'(pkt_fifo_rd_en), W'(0));
        if (phv_fifo_rd_en)
            chk("phv_pop_legal", W'({busy, pkt_q.size() == 0, phv_q.size() == 0}), W'(0));
        if (pkt_fifo_rd_en)
            chk("pkt_pop_legal", W'({busy, pkt_q.size() == 0}), W'(2'b10));
        accept = depar_out_tvalid && depar_out_tready;
        if (accept) begin
            chk("out_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_tdata", depar_out_tdata, e.data);
                chk("out_tkeep", W'(depar_out_tkeep), W'(e.keep));
                chk("out_tuser", W'(depar_out_tuser), W'(e.user));
                chk("out_tlast", W'(depar_out_tlast), W'(e.last));
            end
            e.data = depar_out_tdata; e.keep = depar_out_tkeep;
            e.user = depar_out_tuser; e.last = depar_out_tlast;
            got_log.push_back(e);
            beats_out++;
        end
        do_pkt     = pkt_fifo_rd_en && (pkt_q.size() != 0);
        do_phv     = phv_fifo_rd_en && (phv_q.size() != 0);
        stall_prev = depar_out_tvalid && !depar_out_tready;
        prev_data  = depar_out_tdata;
        @(posedge axis_clk);
        if (do_phv) begin
            ph = phv_q.pop_front();
            phv_pulses++;
            busy     = 1'b1;
            cur_drop = ph.meta[0];
            if (!ph.meta[0]) begin
                for (int j = 0; j < pkt_q.size(); j++) begin
                    e = pkt_q[j];
                    if (!bypass_m && j < HB) e.data = ph.s[j];
                    exp_q.push_back(e);
                    if (pkt_q[j].last) break;
                end
            end
        end
        if (do_pkt) begin
            e = pkt_q.pop_front();
            pkt_pops++;
            if (e.last) busy = 1'b0;
        end
        if (ctrl_go && ctrl_cmd[2:0] == 3'd5 && ctrl_cmd[3]) bypass_m = ctrl_cmd[4];
        cyc++;
        @(negedge axis_clk);
        ctrl_go = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pkt_q.size() != 0 || exp_q.size() != 0 || busy || depar_out_tvalid) && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, W'(pkt_q.size() + exp_q.size() + int'(busy) + int'(depar_out_tvalid)), W'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_tvalid"}, W'(depar_out_tvalid), W'(0));
        chk({tag, "_tdata"}, depar_out_tdata, W'(0));
        chk({tag, "_tkeep"}, W'(depar_out_tkeep), W'(0));
        chk({tag, "_tuser"}, W'(depar_out_tuser), W'(0));
        chk({tag, "_tlast"}, W'(depar_out_tlast), W'(0));
        chk({tag, "_pkt_rd"}, W'(pkt_fifo_rd_en), W'(0));
        chk({tag, "_phv_rd"}, W'(phv_fifo_rd_en), W'(0));
    endtask

    initial begin
        int lat, base_pops, base_pulses, base_out, n;
        logic [4:0] cmds [5];
        aresetn = 1'b0;
        pkt_fifo_tdata = '0; pkt_fifo_tkeep = '0; pkt_fifo_tuser = '0; pkt_fifo_tlast = 1'b0;
        pkt_fifo_empty = 1'b1; phv_fifo_out = '0; phv_fifo_empty = 1'b1;
        depar_out_tready = 1'b1;
        ctrl_s_axis_tdata = '0; ctrl_s_axis_tuser = '0; ctrl_s_axis_tkeep = '0;
        ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tlast = 1'b0;
        repeat (3) @(negedge axis_clk);
        #1 check_outputs_zero("reset");
        @(negedge axis_clk);
        aresetn = 1'b1;
        cycle();

        // Basic rewrite with two-cycle latency check.
        ready_mode = 0;
        got_log.delete();
        push_pkt(6, 1'b1);
        push_phv(1'b0, 1'b1);
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (lat < 0 && got_log.size() != 0) lat = k;
        end
        drain("basic_drain", 50);
        chk("basic_latency", W'(lat), W'(2));
        chk("basic_count", W'(got_log.size()), W'(6));
        for (int i = 0; i < 6 && i < got_log.size(); i++) begin
            chk("basic_data", got_log[i].data, (i < 4) ? W'(8'hA0 + i) : W'(i));
            chk("basic_last", W'(got_log[i].last), W'(i == 5));
        end
        chk("basic_phv_pulses", W'(phv_pulses), W'(1));

        // Short packet then a full one with a fresh PHV.
        base_pulses = phv_pulses;
        push_pkt(2, 1'b0); push_phv(1'b0, 1'b0);
        push_pkt(5, 1'b0); push_phv(1'b0, 1'b0);
        drain("short_drain", 60);
        chk("short_phv_pulses", W'(phv_pulses - base_pulses), W'(2));

        // Discard followed by a normal packet.
        base_pops = pkt_pops; base_out = beats_out;
        push_pkt(3, 1'b0); push_phv(1'b1, 1'b0);
        drain("drop_drain", 40);
        chk("drop_pops", W'(pkt_pops - base_pops), W'(3));
        chk("drop_no_out", W'(beats_out - base_out), W'(0));
        push_pkt(4, 1'b0); push_phv(1'b0, 1'b0);
        drain("after_drop_drain", 40);
        chk("after_drop_out", W'(beats_out - base_out), W'(4));

        // Backpressure with a 1,0,0,1 ready pattern.
        ready_mode = 2;
        base_out = beats_out;
        push_pkt(7, 1'b0); push_phv(1'b0, 1'b0);
        drain("bp_drain", 100);
        chk("bp_count", W'(beats_out - base_out), W'(7));

        // Bypass written mid-packet; a foreign-ID write is ignored.
        ready_mode = 0;
        base_pops = pkt_pops;
        push_pkt(6, 1'b0); push_phv(1'b0, 1'b0);
        n = 0;
        while (pkt_pops - base_pops < 2 && n < 20) begin cycle(); n++; end
        chk("byp_reach_mid", W'(pkt_pops - base_pops), W'(2));
        ctrl_cmd = 5'h1D; ctrl_go = 1'b1; cycle();
        ctrl_cmd = 5'h0B; ctrl_go = 1'b1; cycle();
        push_pkt(4, 1'b0); push_phv(1'b0, 1'b0);
        drain("byp_drain", 60);
        ctrl_cmd = 5'h0D; ctrl_go = 1'b1; cycle();
        push_pkt(3, 1'b0); push_phv(1'b0, 1'b0);
        drain("byp_clear_drain", 40);

        // Bypass on again so reset is seen to clear it.
        ctrl_cmd = 5'h1D; ctrl_go = 1'b1; cycle();
        base_pops = pkt_pops;
        push_pkt(5, 1'b0); push_phv(1'b0, 1'b0);
        push_phv(1'b0, 1'b0);
        n = 0;
        while (pkt_pops - base_pops < 2 && n < 20) begin cycle(); n++; end
        #2 aresetn = 1'b0;
        #1 check_outputs_zero("midreset");
        pkt_q.delete(); phv_q.delete(); exp_q.delete();
        busy = 1'b0; cur_drop = 1'b0; bypass_m = 1'b0; stall_prev = 1'b0;
        @(negedge axis_clk);
        cycle();
        aresetn = 1'b1;
        base_pops = pkt_pops; base_pulses = phv_pulses;
        repeat (3) begin
            cycle();
            chk("post_reset_idle", W'(depar_out_tvalid), W'(0));
        end
        push_pkt(3, 1'b0);
        repeat (3) cycle();
        chk("wait_phv_pkt_pops", W'(pkt_pops - base_pops), W'(0));
        chk("wait_phv_pulses", W'(phv_pulses - base_pulses), W'(0));
        push_phv(1'b0, 1'b0);
        drain("post_reset_drain", 40);

        // Randomised traffic with random ready and control writes.
        cmds[0] = 5'h1D; cmds[1] = 5'h0D; cmds[2] = 5'h0B; cmds[3] = 5'h15; cmds[4] = 5'h1C;
        ready_mode = 1;
        for (int p = 0; p < 30; p++) begin
            push_pkt($urandom_range(1, 8), 1'b0);
            push_phv($urandom_range(0, 4) == 0, 1'b0);
            repeat ($urandom_range(0, 6)) begin
                if ($urandom_range(0, 7) == 0) begin
                    ctrl_cmd = cmds[$urandom_range(0, 4)];
                    ctrl_go  = 1'b1;
                end
                cycle();
            end
        end
        drain("random_drain", 2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
